core_mc: RTL and testbench

Parametrised multicycle load/store processor core, the next generation of the team's 16-bit three-stage core. Instruction fetch, two-word operand fetch, data access and execute are sequenced by one FSM against a single-port memory with a ready handshake, so wait-state memories and banked address spaces work unchanged. Adds configurable data/address width and register count, a working `jal`, `halt`, and hardwired-zero R0. Sits between the memory/bus fabric and the top level.

---
 rtl/core_mc.sv | 190 +++++++++++++++++++
 tb/tb_core_mc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mc.sv
// core_mc: multicycle load/store core sequencing fetch, operand fetch, data
// access and execute against one single-port memory with a ready handshake.
module core_mc #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 24,
    parameter int unsigned       NUM_REGS = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {StFetch, StOperand, StMem, StExec, StHalt} state_e;

    localparam logic [3:0] OpAdd   = 4'h0;
    localparam logic [3:0] OpAddi  = 4'h1;
    localparam logic [3:0] OpSub   = 4'h2;
    localparam logic [3:0] OpLoad  = 4'h3;
    localparam logic [3:0] OpStore = 4'h4;
    localparam logic [3:0] OpSeq   = 4'h5;
    localparam logic [3:0] OpSlt   = 4'h6;
    localparam logic [3:0] OpBeq   = 4'h7;
    localparam logic [3:0] OpJ     = 4'h8;
    localparam logic [3:0] OpJal   = 4'h9;
    localparam logic [3:0] OpShr   = 4'hA;
    localparam logic [3:0] OpShl   = 4'hB;
    localparam logic [3:0] OpNand  = 4'hC;
    localparam logic [3:0] OpLoadi = 4'hD;
    localparam logic [3:0] OpWr    = 4'hE;
    localparam logic [3:0] OpHalt  = 4'hF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] w2_q, w2_d;
    logic [DATA_W-1:0] regs_q [16];

    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [3:0]        op_f, rd_f, rs_f, rt_f, fetch_op;
    logic [DATA_W-1:0] rd_val, rs_val, rt_val, rt_sext;
    logic [ADDR_W-1:0] immj, w2_addr, pc_inc1, pc_inc2;

    assign op_f     = ir_q[DATA_W-1 -: 4];
    assign rd_f     = ir_q[DATA_W-5 -: 4];
    assign rs_f     = ir_q[DATA_W-9 -: 4];
    assign rt_f     = ir_q[DATA_W-13 -: 4];
    assign fetch_op = mem_rdata[DATA_W-1 -: 4];
    assign rt_sext  = {{(DATA_W-4){rt_f[3]}}, rt_f};
    assign immj     = ADDR_W'(ir_q[DATA_W-5:0]);
    assign w2_addr  = ADDR_W'(w2_q);
    assign pc_inc1  = pc_q + ADDR_W'(1);
    assign pc_inc2  = pc_q + ADDR_W'(2);
    assign halted   = (state_q == StHalt);
    assign pc       = pc_q;

    // Register reads: R0 and indices beyond NUM_REGS read as zero.
    always_comb begin
        rd_val = (rd_f != 4'd0 && 32'(rd_f) < NUM_REGS) ? regs_q[rd_f] : '0;
        rs_val = (rs_f != 4'd0 && 32'(rs_f) < NUM_REGS) ? regs_q[rs_f] : '0;
        rt_val = (rt_f != 4'd0 && 32'(rt_f) < NUM_REGS) ? regs_q[rt_f] : '0;
    end

    // Register file write port; writes to R0 or out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_waddr != 4'd0 && 32'(rf_waddr) < NUM_REGS) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // State, PC and instruction latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            w2_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            w2_q    <= w2_d;
        end
    end

    // Next-state, memory request and register write decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        w2_d      = w2_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = '0;
        rf_we     = 1'b0;
        rf_waddr  = rd_f;
        rf_wdata  = '0;
        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d = mem_rdata;
                    case (fetch_op)
                        OpLoad, OpStore, OpBeq: state_d = StOperand;
                        OpWr:                   state_d = StMem;
                        OpHalt:                 state_d = StHalt;
                        default:                state_d = StExec;
                    endcase
                end
            end
            StOperand: begin
                mem_req  = 1'b1;
                mem_addr = pc_inc1;
                if (mem_ready) begin
                    w2_d = mem_rdata;
                    if (op_f == OpBeq) begin
                        pc_d    = (rd_val == rs_val) ? ADDR_W'(mem_rdata) : pc_inc2;
                        state_d = StFetch;
                    end else begin
                        state_d = StMem;
                    end
                end
            end
            StMem: begin
                mem_req = 1'b1;
                if (op_f == OpWr) begin
                    mem_we    = 1'b1;
                    mem_addr  = ADDR_W'(rs_val);
                    mem_wdata = rd_val;
                end else begin
                    mem_we    = (op_f == OpStore);
                    mem_addr  = w2_addr;
                    mem_wdata = (op_f == OpStore) ? rd_val : '0;
                end
                if (mem_ready) begin
                    state_d = StFetch;
                    pc_d    = (op_f == OpWr) ? pc_inc1 : pc_inc2;
                    if (op_f == OpLoad) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                end
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_inc1;
                rf_we   = 1'b1;
                case (op_f)
                    OpAdd:   rf_wdata = rs_val + rt_val;
                    OpAddi:  rf_wdata = rs_val + rt_sext;
                    OpSub:   rf_wdata = rs_val - rt_val;
                    OpSeq:   rf_wdata = {{(DATA_W-1){1'b0}}, rs_val == rt_val};
                    OpSlt:   rf_wdata = {{(DATA_W-1){1'b0}}, $signed(rs_val) < $signed(rt_val)};
                    OpShr:   rf_wdata = rs_val >> rt_f;
                    OpShl:   rf_wdata = rs_val << rt_f;
                    OpNand:  rf_wdata = ~(rs_val & rt_val);
                    OpLoadi: rf_wdata = DATA_W'(ir_q[7:0]);
                    OpJ: begin
                        rf_we = 1'b0;
                        pc_d  = immj;
                    end
                    OpJal: begin
                        rf_waddr = 4'd15;
                        rf_wdata = DATA_W'(pc_inc1);
                        pc_d     = immj;
                    end
                    default: rf_we = 1'b0;
                endcase
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: directed program runs on two builds (16-bit default and a
// 32-bit, 8-register build that starts at the top of the address space).
module tb_core_mc;

    logic        clk;
    logic        rst_n, rst_nb;
    logic        hold_a;
    logic        load_img;

    logic [15:0] mem_rdata_a, mem_wdata_a;
    logic        mem_ready_a, mem_req_a, mem_we_a, halted_a;
    logic [23:0] mem_addr_a, pc_a;

    logic [31:0] mem_rdata_b, mem_wdata_b;
    logic        mem_ready_b, mem_req_b, mem_we_b, halted_b;
    logic [23:0] mem_addr_b, pc_b;

    logic [15:0] img_a [256];
    logic [15:0] mem_a [256];
    logic [31:0] img_b [256];
    logic [31:0] mem_b [256];

    int total;
    int bad;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] expv;
        string       name;
    } vec_t;
    vec_t vecs [13];

    core_mc u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_rdata (mem_rdata_a),
        .mem_ready (mem_ready_a),
        .mem_req   (mem_req_a),
        .mem_we    (mem_we_a),
        .mem_addr  (mem_addr_a),
        .mem_wdata (mem_wdata_a),
        .halted    (halted_a),
        .pc        (pc_a)
    );

    core_mc #(
        .DATA_W   (32),
        .ADDR_W   (24),
        .NUM_REGS (8),
        .RESET_PC (24'hFFFFFF)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_nb),
        .mem_rdata (mem_rdata_b),
        .mem_ready (mem_ready_b),
        .mem_req   (mem_req_b),
        .mem_we    (mem_we_b),
        .mem_addr  (mem_addr_b),
        .mem_wdata (mem_wdata_b),
        .halted    (halted_b),
        .pc        (pc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata_a = mem_a[mem_addr_a[7:0]];
    assign mem_ready_a = !hold_a;
    assign mem_rdata_b = mem_b[mem_addr_b[7:0]];
    assign mem_ready_b = 1'b1;

    // Memory models: image load, then committed writes on ready.
    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= img_a[i];
                mem_b[i] <= img_b[i];
            end
        end else begin
            if (mem_req_a && mem_we_a && mem_ready_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
            if (mem_req_b && mem_we_b && mem_ready_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run until PC changes (bounded); check new PC and cycle count.
    task automatic step(input logic [23:0] exp_pc, input int exp_cyc, input string name);
        int          n;
        logic [23:0] p0;
        n  = 0;
        p0 = pc_a;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (pc_a == p0 && n < 50);
        chk({name, "_pc"}, 64'(pc_a), 64'(exp_pc));
        chk({name, "_cycles"}, 64'(n), 64'(exp_cyc));
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_req"}, 64'(mem_req_a), 64'(1));
        chk({name, "_we"}, 64'(mem_we_a), 64'(0));
        chk({name, "_addr"}, 64'(mem_addr_a), 64'(0));
        chk({name, "_wdata"}, 64'(mem_wdata_a), 64'(0));
        chk({name, "_halted"}, 64'(halted_a), 64'(0));
        chk({name, "_pc"}, 64'(pc_a), 64'(0));
    endtask

    initial begin
        int n;
        total    = 0;
        bad      = 0;
        hold_a   = 1'b0;
        rst_n    = 1'b0;
        rst_nb   = 1'b0;
        load_img = 1'b1;

        vecs[0]  = '{16'h1A1F, 16'h0004, "addi_neg"};
        vecs[1]  = '{16'h1A17, 16'h000C, "addi_pos"};
        vecs[2]  = '{16'h5A11, 16'h0001, "seq_eq"};
        vecs[3]  = '{16'h5A12, 16'h0000, "seq_ne"};
        vecs[4]  = '{16'h6A41, 16'h0001, "slt_neg_lt"};
        vecs[5]  = '{16'h6A14, 16'h0000, "slt_pos_ge"};
        vecs[6]  = '{16'hAA43, 16'h1FFF, "shr3"};
        vecs[7]  = '{16'hBA14, 16'h0050, "shl4"};
        vecs[8]  = '{16'hCA12, 16'hFFFE, "nand"};
        vecs[9]  = '{16'h0A34, 16'h0006, "add_wrap"};
        vecs[10] = '{16'h2A12, 16'h0002, "sub"};
        vecs[11] = '{16'hDAAB, 16'h00AB, "loadi"};
        vecs[12] = '{16'hAA10, 16'h0005, "shr0"};

        for (int i = 0; i < 256; i++) begin
            img_a[i] = 16'h0000;
            img_b[i] = 32'h0;
        end
        img_a[8'h00] = 16'hD105; img_a[8'h01] = 16'hD203;
        img_a[8'h02] = 16'h0312; img_a[8'h03] = 16'h2421;
        img_a[8'h04] = 16'h4300; img_a[8'h05] = 16'h0040;
        img_a[8'h06] = 16'h3500; img_a[8'h07] = 16'h0040;
        img_a[8'h08] = 16'hD641; img_a[8'h09] = 16'hE560;
        img_a[8'h0A] = 16'hD742; img_a[8'h0B] = 16'hE470;
        img_a[8'h0C] = 16'h7110; img_a[8'h0D] = 16'h0020;
        img_a[8'h20] = 16'h7120; img_a[8'h21] = 16'h0050;
        img_a[8'h22] = 16'h8010; img_a[8'h10] = 16'h9030;
        img_a[8'h30] = 16'hD007; img_a[8'h31] = 16'hD843;
        img_a[8'h32] = 16'hEF80; img_a[8'h33] = 16'hD944;
        img_a[8'h34] = 16'hE090; img_a[8'h35] = 16'hDB80;
        img_a[8'h36] = 16'h8050;
        for (int i = 0; i < 13; i++) begin
            img_a[8'h50 + 3 * i]     = vecs[i].instr;
            img_a[8'h50 + 3 * i + 1] = 16'hEAB0;
            img_a[8'h50 + 3 * i + 2] = 16'h1BB1;
        end
        img_a[8'h77] = 16'hF000;

        img_b[8'hFF] = 32'hD100_0005; img_b[8'h00] = 32'hD200_0003;
        img_b[8'h01] = 32'h0312_0000; img_b[8'h02] = 32'h2421_0000;
        img_b[8'h03] = 32'hD900_0077; img_b[8'h04] = 32'hD600_0040;
        img_b[8'h05] = 32'hE360_0000; img_b[8'h06] = 32'hD600_0041;
        img_b[8'h07] = 32'hE460_0000; img_b[8'h08] = 32'hD700_0042;
        img_b[8'h09] = 32'hE970_0000; img_b[8'h0A] = 32'hD700_0043;
        img_b[8'h0B] = 32'hE170_0000; img_b[8'h0C] = 32'h9000_0020;
        img_b[8'h20] = 32'h4300_0000; img_b[8'h21] = 32'h0000_0044;
        img_b[8'h22] = 32'h3500_0000; img_b[8'h23] = 32'h0000_0044;
        img_b[8'h24] = 32'hD700_0045; img_b[8'h25] = 32'hE570_0000;
        img_b[8'h26] = 32'hF000_0000;

        @(posedge clk); #1;
        load_img = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        step(24'h01, 2, "loadi_r1");
        step(24'h02, 2, "loadi_r2");
        step(24'h03, 2, "add");
        step(24'h04, 2, "sub");

        // Store: observe the write request in MEM.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("store_we", 64'(mem_we_a), 64'(1));
        chk("store_addr", 64'(mem_addr_a), 64'h40);
        chk("store_wdata", 64'(mem_wdata_a), 64'(8));
        @(posedge clk); #1;
        chk("store_pc", 64'(pc_a), 64'h06);
        chk("store_mem", 64'(mem_a[8'h40]), 64'(8));

        // Load with three wait cycles in MEM.
        @(posedge clk); #1;
        @(posedge clk); #1;
        hold_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("load_wait_req", 64'(mem_req_a), 64'(1));
            chk("load_wait_we", 64'(mem_we_a), 64'(0));
            chk("load_wait_addr", 64'(mem_addr_a), 64'h40);
            chk("load_wait_pc", 64'(pc_a), 64'h06);
            @(posedge clk); #1;
        end
        chk("load_stalled_pc", 64'(pc_a), 64'h06);
        hold_a = 1'b0;
        @(posedge clk); #1;
        chk("load_pc", 64'(pc_a), 64'h08);

        step(24'h09, 2, "loadi_r6");
        step(24'h0A, 2, "wr_r5");
        step(24'h0B, 2, "loadi_r7");
        step(24'h0C, 2, "wr_r4");
        step(24'h20, 2, "beq_taken");
        step(24'h22, 2, "beq_not_taken");
        step(24'h10, 2, "j");
        step(24'h30, 2, "jal");
        step(24'h31, 2, "loadi_r0");
        step(24'h32, 2, "loadi_r8");
        step(24'h33, 2, "wr_r15");
        step(24'h34, 2, "loadi_r9");
        step(24'h35, 2, "wr_r0");
        step(24'h36, 2, "loadi_r11");
        step(24'h50, 2, "j_table");

        chk("load_result", 64'(mem_a[8'h41]), 64'(8));
        chk("sub_result", 64'(mem_a[8'h42]), 64'hFFFE);
        chk("jal_link", 64'(mem_a[8'h43]), 64'h11);
        chk("r0_zero", 64'(mem_a[8'h44]), 64'(0));

        for (int i = 0; i < 13; i++) begin
            step(24'(8'h50 + 3 * i + 1), 2, vecs[i].name);
            step(24'(8'h50 + 3 * i + 2), 2, "vec_wr");
            step(24'(8'h50 + 3 * i + 3), 2, "vec_addi");
            chk(vecs[i].name, 64'(mem_a[8'h80 + i]), 64'(vecs[i].expv));
        end

        // Halt: asserted one cycle after fetch, then no requests.
        @(posedge clk); #1;
        chk("halted", 64'(halted_a), 64'(1));
        for (int i = 0; i < 4; i++) begin
            chk("halt_req", 64'(mem_req_a), 64'(0));
            @(posedge clk); #1;
        end
        chk("halt_hold", 64'(halted_a), 64'(1));
        chk("halt_pc", 64'(pc_a), 64'h77);

        // Reset pulse in the middle of a MEM wait.
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("reset_after_halt");
        rst_n = 1'b1;
        step(24'h01, 2, "rerun_1");
        step(24'h02, 2, "rerun_2");
        step(24'h03, 2, "rerun_3");
        step(24'h04, 2, "rerun_4");
        step(24'h06, 3, "rerun_store");
        @(posedge clk); #1;
        @(posedge clk); #1;
        hold_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("reset_mid_wait");
        hold_a = 1'b0;
        rst_n  = 1'b1;
        step(24'h01, 2, "restart");

        // Wide build: PC wrap, NUM_REGS=8 and DATA_W=32.
        rst_nb = 1'b1;
        chk("b_reset_pc", 64'(pc_b), 64'hFFFFFF);
        chk("b_reset_addr", 64'(mem_addr_b), 64'hFFFFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b_pc_wrap", 64'(pc_b), 64'(0));
        n = 0;
        while (!halted_b && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_halted", 64'(halted_b), 64'(1));
        chk("b_halt_pc", 64'(pc_b), 64'h26);
        chk("b_add", 64'(mem_b[8'h40]), 64'(8));
        chk("b_sub", 64'(mem_b[8'h41]), 64'hFFFF_FFFE);
        chk("b_r9_reads_zero", 64'(mem_b[8'h42]), 64'(0));
        chk("b_r9_no_alias", 64'(mem_b[8'h43]), 64'(5));
        chk("b_store", 64'(mem_b[8'h44]), 64'(8));
        chk("b_load", 64'(mem_b[8'h45]), 64'(8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
